// File: rtl/ftb_assoc_bank.sv
// rtl/ftb_assoc_bank.sv - set-associative fetch target buffer bank with init sweep
//
// Purpose: one FTB bank. Lookups return hit/way/info/direction one cycle after
// acceptance. Updates are written one cycle after acceptance; an update that hits
// refreshes the entry and steps its saturating counter, an update that misses
// allocates a victim way only when update_alloc is set. After reset an INIT sweep
// clears the valid bits and replacement pointer of one set per cycle.
//
// Info layout (ftbInfo_t): {br_type[1:0], target[XLEN-1:0]}; responses append the
// CNT_WIDTH-bit direction counter in the least significant bits.
//
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   lookup_vld/pc/rdy            lookup request (rdy low during the INIT sweep)
//   resp_vld/hit/way/info/taken  lookup response, one cycle after acceptance
//   update_vld/rdy/pc/taken      update request (rdy mirrors lookup_rdy)
//   update_alloc, update_info    allocate-on-miss enable and info fields to write
//
// Configuration macro: FTB_UPDATE_BYPASS_EN -- when defined, a write landing in the
// same cycle a lookup response is formed for the same set is reflected in it.

`ifndef FTB_TAG_WIDTH
`define FTB_TAG_WIDTH 20
`endif

module ftb_assoc_bank #(
   parameter int SETS      = 64,
   parameter int WAYS      = 4,
   parameter int TAG_WIDTH = `FTB_TAG_WIDTH,
   parameter int CNT_WIDTH = 2,
   parameter int XLEN      = 32,
   localparam int IDX_W    = $clog2(SETS),
   localparam int WAY_W    = $clog2(WAYS),
   localparam int INFO_W   = 2 + XLEN
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        lookup_vld,
   input  logic [XLEN-1:0]             lookup_pc,
   output logic                        lookup_rdy,
   output logic                        resp_vld,
   output logic                        resp_hit,
   output logic [WAY_W-1:0]            resp_way,
   output logic [INFO_W+CNT_WIDTH-1:0] resp_info,
   output logic                        resp_taken,
   input  logic                        update_vld,
   output logic                        update_rdy,
   input  logic [XLEN-1:0]             update_pc,
   input  logic                        update_taken,
   input  logic                        update_alloc,
   input  logic [INFO_W-1:0]           update_info
);

   localparam logic [CNT_WIDTH-1:0] CNT_MAX    = '1;
   localparam logic [CNT_WIDTH-1:0] CNT_WEAK_T = CNT_WIDTH'(1 << (CNT_WIDTH - 1));
   localparam logic [CNT_WIDTH-1:0] CNT_WEAK_N = CNT_WIDTH'((1 << (CNT_WIDTH - 1)) - 1);

   typedef enum logic {S_INIT, S_RUN} state_t;

   state_t           state;
   logic [IDX_W-1:0] sweep_idx;
   logic             rdy_q;

   // storage
   logic [WAYS-1:0]      vld_q  [SETS];
   logic [TAG_WIDTH-1:0] tag_q  [SETS][WAYS];
   logic [INFO_W-1:0]    info_q [SETS][WAYS];
   logic [CNT_WIDTH-1:0] cnt_q  [SETS][WAYS];
   logic [WAY_W-1:0]     ptr_q  [SETS];

   // lookup stage
   logic                 lk_acc;
   logic                 lk_vld_q;
   logic [IDX_W-1:0]     lk_idx_q;
   logic [TAG_WIDTH-1:0] lk_tag_q;

   // pending write stage
   logic                 up_acc;
   logic                 wr_vld_q;
   logic [IDX_W-1:0]     wr_idx_q;
   logic [TAG_WIDTH-1:0] wr_tag_q;
   logic                 wr_taken_q;
   logic                 wr_alloc_q;
   logic [INFO_W-1:0]    wr_info_q;

   logic                 wr_hit;
   logic [WAY_W-1:0]     wr_hit_way;
   logic [WAY_W-1:0]     wr_victim;
   logic [WAY_W-1:0]     wr_way;
   logic [CNT_WIDTH-1:0] wr_cur;
   logic [CNT_WIDTH-1:0] wr_cnt;
   logic                 wr_en;

   logic                 lk_hit;
   logic [WAY_W-1:0]     lk_way;
   logic [INFO_W-1:0]    lk_info;
   logic [CNT_WIDTH-1:0] lk_cnt;
   logic                 e_vld;
   logic [TAG_WIDTH-1:0] e_tag;
   logic [INFO_W-1:0]    e_info;
   logic [CNT_WIDTH-1:0] e_cnt;

   // pc bit 0 and the bits above the tag do not take part in indexing or tagging
   logic unused_pc_bits;
   assign unused_pc_bits = ^{lookup_pc[0], lookup_pc[XLEN-1:TAG_WIDTH+IDX_W+1],
                             update_pc[0], update_pc[XLEN-1:TAG_WIDTH+IDX_W+1]};

   // rst gates the handshake combinationally so nothing is accepted during the reset cycle
   assign lookup_rdy = rdy_q & ~rst;
   assign update_rdy = lookup_rdy;
   assign lk_acc     = lookup_vld & lookup_rdy;
   assign up_acc     = update_vld & update_rdy;

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= S_INIT;
         sweep_idx <= '0;
         rdy_q     <= 1'b0;
      end else begin
         case (state)
            S_INIT: begin
               sweep_idx <= sweep_idx + IDX_W'(1);
               if (sweep_idx == IDX_W'(SETS - 1)) begin
                  state <= S_RUN;
                  rdy_q <= 1'b1;
               end
            end
            S_RUN: ;
            default: state <= S_INIT;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         lk_vld_q <= 1'b0;
         wr_vld_q <= 1'b0;
      end else begin
         lk_vld_q <= lk_acc;
         wr_vld_q <= up_acc;
      end
      if (lk_acc) begin
         lk_idx_q <= lookup_pc[IDX_W:1];
         lk_tag_q <= lookup_pc[TAG_WIDTH+IDX_W:IDX_W+1];
      end
      if (up_acc) begin
         wr_idx_q   <= update_pc[IDX_W:1];
         wr_tag_q   <= update_pc[TAG_WIDTH+IDX_W:IDX_W+1];
         wr_taken_q <= update_taken;
         wr_alloc_q <= update_alloc;
         wr_info_q  <= update_info;
      end
   end

   // Resolve the pending write against current contents. Scanning from the top way
   // down leaves the lowest matching / lowest invalid way as the final assignment.
   always_comb begin
      wr_hit     = 1'b0;
      wr_hit_way = '0;
      wr_victim  = ptr_q[wr_idx_q];
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (vld_q[wr_idx_q][w] && tag_q[wr_idx_q][w] == wr_tag_q) begin
            wr_hit     = 1'b1;
            wr_hit_way = WAY_W'(w);
         end
         if (!vld_q[wr_idx_q][w])
            wr_victim = WAY_W'(w);
      end
      wr_way = wr_hit ? wr_hit_way : wr_victim;
      wr_cur = cnt_q[wr_idx_q][wr_hit_way];
      if (wr_hit) begin
         if (wr_taken_q)
            wr_cnt = (wr_cur == CNT_MAX) ? wr_cur : wr_cur + CNT_WIDTH'(1);
         else
            wr_cnt = (wr_cur == '0) ? wr_cur : wr_cur - CNT_WIDTH'(1);
      end else begin
         wr_cnt = wr_taken_q ? CNT_WEAK_T : CNT_WEAK_N;
      end
      // a miss without alloc is dropped entirely
      wr_en = wr_vld_q & ~rst & (wr_hit | wr_alloc_q);
   end

   always_ff @(posedge clk) begin
      if (!rst && state == S_INIT) begin
         vld_q[sweep_idx] <= '0;
         ptr_q[sweep_idx] <= '0;
      end else if (wr_en) begin
         vld_q[wr_idx_q][wr_way]  <= 1'b1;
         tag_q[wr_idx_q][wr_way]  <= wr_tag_q;
         info_q[wr_idx_q][wr_way] <= wr_info_q;
         cnt_q[wr_idx_q][wr_way]  <= wr_cnt;
         if (!wr_hit)
            ptr_q[wr_idx_q] <= ptr_q[wr_idx_q] + WAY_W'(1);
      end
   end

   // Response is formed from the array in the cycle after acceptance; the pending
   // write lands at the end of that same cycle, so by default it is not visible.
   always_comb begin
      lk_hit  = 1'b0;
      lk_way  = '0;
      lk_info = '0;
      lk_cnt  = '0;
      e_vld   = 1'b0;
      e_tag   = '0;
      e_info  = '0;
      e_cnt   = '0;
      for (int w = WAYS - 1; w >= 0; w--) begin
         e_vld  = vld_q[lk_idx_q][w];
         e_tag  = tag_q[lk_idx_q][w];
         e_info = info_q[lk_idx_q][w];
         e_cnt  = cnt_q[lk_idx_q][w];
`ifdef FTB_UPDATE_BYPASS_EN
         if (wr_en && wr_idx_q == lk_idx_q && wr_way == WAY_W'(w)) begin
            e_vld  = 1'b1;
            e_tag  = wr_tag_q;
            e_info = wr_info_q;
            e_cnt  = wr_cnt;
         end
`endif
         if (e_vld && e_tag == lk_tag_q) begin
            lk_hit  = 1'b1;
            lk_way  = WAY_W'(w);
            lk_info = e_info;
            lk_cnt  = e_cnt;
         end
      end
   end

   assign resp_vld   = lk_vld_q & ~rst;
   assign resp_hit   = resp_vld & lk_hit;
   assign resp_way   = resp_hit ? lk_way : '0;
   assign resp_info  = resp_hit ? {lk_info, lk_cnt} : '0;
   assign resp_taken = resp_hit & lk_cnt[CNT_WIDTH-1];

endmodule

// File: doc/ftb_assoc_bank.md
FTB_ASSOC_BANK -- requirements
Module: ftb_assoc_bank

Interface
REQ-001 SHALL have parameter SETS, default 64, number of sets (power of 2, >=2).
REQ-002 SHALL have parameter WAYS, default 4, ways per set (power of 2, >=2).
REQ-003 SHALL have parameter TAG_WIDTH, default `FTB_TAG_WIDTH, stored tag bits.
REQ-004 SHALL have parameter CNT_WIDTH, default 2, direction counter width (1..4).
REQ-005 SHALL have clk  input  1  the single clock; all state changes on its rising edge.
REQ-006 SHALL have rst  input  1  synchronous, active-high reset.
REQ-007 SHALL have lookup_vld  input  1; lookup_pc  input  XLEN; lookup_rdy  output  1, low while init sweep runs.
REQ-008 SHALL have resp_vld  output  1; resp_hit  output  1; resp_way  output  log2(WAYS).
REQ-009 SHALL have resp_info  output  ftbInfo_t-layout fields, with counter widened to CNT_WIDTH; resp_taken  output  1, the counter MSB.
REQ-010 SHALL have update_vld  input  1; update_rdy  output  1; update_pc  input  XLEN; update_taken  input  1; update_alloc  input  1.
REQ-011 SHALL have update_info  input  ftbInfo_t-layout fields, excluding counter.

Function
REQ-012 SHALL index by pc[log2(SETS):1] and tag by pc[TAG_WIDTH+log2(SETS):log2(SETS)+1].
REQ-013 SHALL, on an accepted lookup (lookup_vld & lookup_rdy) in cycle N, drive resp_* in cycle N+1 with resp_vld=1 for exactly one cycle.
REQ-014 SHALL define a hit as vld & tag match in any way; on a multi-way hit, report the lowest-numbered way.
REQ-015 SHALL drive resp_hit=0, resp_info=0 and resp_way=0 on a miss.
REQ-016 SHALL, on update hit: overwrite the info fields; step the counter with saturation (+1 capped at 2^CNT_WIDTH-1 if taken, -1 floored at 0 otherwise); leave the replacement pointer unchanged.
REQ-017 SHALL, on update miss with update_alloc=1, allocate a victim way:
  - victim is the lowest invalid way, else the set's round-robin pointer;
  - write tag, vld=1 and info;
  - initialise the counter to 2^(CNT_WIDTH-1) if taken, else 2^(CNT_WIDTH-1)-1;
  - advance the pointer modulo WAYS.
REQ-018 SHALL drop an update miss with update_alloc=0 without changing any state.
REQ-019 SHALL write an update one cycle after acceptance; update_rdy equals lookup_rdy.
REQ-020 SHALL, when a lookup and an update to the same set occur in the same cycle, return pre-update (old) contents on the lookup (see REQ-026).
REQ-021 SHALL implement FSM INIT->RUN:
  - INIT clears vld and the pointer of one set per cycle, sets 0..SETS-1 ascending;
  - RUN is entered after set SETS-1 is cleared;
  - lookup_rdy=0 and update_rdy=0 in INIT;
  - inputs presented in INIT are ignored.

Reset
REQ-022 SHALL, while rst=1: enter INIT at set 0; force resp_vld=0, resp_hit=0, lookup_rdy=0, update_rdy=0; discard any in-flight lookup response and pending write.
REQ-023 SHALL restart the full sweep on rst asserted mid-sweep or mid-operation; first accepted request comes SETS cycles after rst deasserts.

Configuration
REQ-024 SHALL compile an update-to-lookup bypass only when macro FTB_UPDATE_BYPASS_EN is defined.
REQ-025 SHALL, without FTB_UPDATE_BYPASS_EN, follow REQ-020 exactly.
REQ-026 SHALL, with FTB_UPDATE_BYPASS_EN, reflect a same-cycle same-set write (including allocation and counter step) in that lookup's response.

Verification
REQ-027 SHALL cover: rst 1 cycle, SETS=4 -> lookup_rdy=0 for 4 cycles after deassert, then 1; resp_vld=0 throughout.
REQ-028 SHALL cover: CNT_WIDTH=3, alloc pc=0x1000 taken -> lookup 0x1000 gives hit, counter=4, taken=1; three taken updates -> counter 7; a fourth -> counter stays 7.
REQ-029 SHALL cover: WAYS=2, three allocs to one set with distinct tags -> ways 0 and 1 filled, third replaces way 0; lookup of first pc -> resp_hit=0.
REQ-030 SHALL cover: update miss with update_alloc=0 -> next lookup resp_hit=0; pointer unchanged.
REQ-031 SHALL cover: same-cycle alloc and lookup of pc 0x2000 -> resp_hit=0 without macro, resp_hit=1 with FTB_UPDATE_BYPASS_EN.
REQ-032 SHALL cover: rst asserted at sweep set 2 -> sweep restarts at set 0; lookup_rdy rises only after 4 further cycles.
